// File: rtl/pipe_reg_de.sv
// Decode-to-execute pipeline register with stall/flush handling and a
// free-running bubble counter for performance debug.
module pipe_reg_de #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_E,
  input  logic             flush_E,
  input  logic             valid_D,
  input  logic             regWrite_D,
  input  logic             jump_D,
  input  logic             branch_D,
  input  logic             ALUsrc_D,
  input  logic             jalr_D,
  input  logic             lui_D,
  input  logic             load_extend_s_D,
  input  logic [1:0]       resultSrc_D,
  input  logic [3:0]       ALUctrl_D,
  input  logic [2:0]       R_size_D,
  input  logic [2:0]       DMem_size_D,
  input  logic [4:0]       Rd_D,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [WIDTH-1:0] RD1_D,
  input  logic [WIDTH-1:0] RD2_D,
  input  logic [WIDTH-1:0] ImmExt_D,
  input  logic [WIDTH-1:0] PC_D,
  input  logic [WIDTH-1:0] PCPlus4_D,
  output logic             valid_E,
  output logic             regWrite_E,
  output logic             jump_E,
  output logic             branch_E,
  output logic             ALUsrc_E,
  output logic             jalr_E,
  output logic             lui_E,
  output logic             load_extend_s_E,
  output logic [1:0]       resultSrc_E,
  output logic [3:0]       ALUctrl_E,
  output logic [2:0]       R_size_E,
  output logic [2:0]       DMem_size_E,
  output logic [4:0]       Rd_E,
  output logic [4:0]       Rs1_E,
  output logic [4:0]       Rs2_E,
  output logic [WIDTH-1:0] RD1_E,
  output logic [WIDTH-1:0] RD2_E,
  output logic [WIDTH-1:0] ImmExt_E,
  output logic [WIDTH-1:0] PC_E,
  output logic [WIDTH-1:0] PCPlus4_E,
  output logic [15:0]      bubble_cnt
);

  localparam int BUS_W = 35 + 5 * WIDTH;

  logic [BUS_W-1:0] bus_D;
  logic [BUS_W-1:0] bus_p0;

  assign bus_D = {valid_D, regWrite_D, jump_D, branch_D, ALUsrc_D, jalr_D, lui_D,
                  load_extend_s_D, resultSrc_D, ALUctrl_D, R_size_D, DMem_size_D,
                  Rd_D, Rs1_D, Rs2_D, RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D};

  // Stage boundary D -> E; flush outranks stall so a taken branch can kill a
  // load-use-stalled instruction. The all-zero bubble keeps Rd_E = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_p0     <= '0;
      bubble_cnt <= '0;
    end else if (flush_E) begin
      bus_p0     <= '0;
      bubble_cnt <= bubble_cnt + 16'd1;
    end else if (!stall_E) begin
      bus_p0     <= bus_D;
    end
  end

  assign {valid_E, regWrite_E, jump_E, branch_E, ALUsrc_E, jalr_E, lui_E,
          load_extend_s_E, resultSrc_E, ALUctrl_E, R_size_E, DMem_size_E,
          Rd_E, Rs1_E, Rs2_E, RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E} = bus_p0;

endmodule

// File: tb/tb_pipe_reg_de.sv
// Directed bench for pipe_reg_de: reset, pass-through, stall, flush,
// flush-over-stall and bubble counter wrap.
module tb_pipe_reg_de;

  localparam int W = 32;
  localparam int BW = 35 + 5 * W;

  logic clk, rst, stall_E, flush_E;
  logic valid_D, regWrite_D, jump_D, branch_D, ALUsrc_D, jalr_D, lui_D, load_extend_s_D;
  logic [1:0] resultSrc_D;
  logic [3:0] ALUctrl_D;
  logic [2:0] R_size_D, DMem_size_D;
  logic [4:0] Rd_D, Rs1_D, Rs2_D;
  logic [W-1:0] RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D;
  logic valid_E, regWrite_E, jump_E, branch_E, ALUsrc_E, jalr_E, lui_E, load_extend_s_E;
  logic [1:0] resultSrc_E;
  logic [3:0] ALUctrl_E;
  logic [2:0] R_size_E, DMem_size_E;
  logic [4:0] Rd_E, Rs1_E, Rs2_E;
  logic [W-1:0] RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E;
  logic [15:0] bubble_cnt;
  logic [BW-1:0] e_bus;

  int compared = 0;
  int mismatched = 0;

  pipe_reg_de #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .stall_E(stall_E), .flush_E(flush_E),
    .valid_D(valid_D), .regWrite_D(regWrite_D), .jump_D(jump_D), .branch_D(branch_D),
    .ALUsrc_D(ALUsrc_D), .jalr_D(jalr_D), .lui_D(lui_D), .load_extend_s_D(load_extend_s_D),
    .resultSrc_D(resultSrc_D), .ALUctrl_D(ALUctrl_D), .R_size_D(R_size_D),
    .DMem_size_D(DMem_size_D), .Rd_D(Rd_D), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .valid_E(valid_E), .regWrite_E(regWrite_E), .jump_E(jump_E), .branch_E(branch_E),
    .ALUsrc_E(ALUsrc_E), .jalr_E(jalr_E), .lui_E(lui_E), .load_extend_s_E(load_extend_s_E),
    .resultSrc_E(resultSrc_E), .ALUctrl_E(ALUctrl_E), .R_size_E(R_size_E),
    .DMem_size_E(DMem_size_E), .Rd_E(Rd_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExt_E(ImmExt_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E),
    .bubble_cnt(bubble_cnt)
  );

  assign e_bus = {valid_E, regWrite_E, jump_E, branch_E, ALUsrc_E, jalr_E, lui_E,
                  load_extend_s_E, resultSrc_E, ALUctrl_E, R_size_E, DMem_size_E,
                  Rd_E, Rs1_E, Rs2_E, RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, hand-derivable value in every field, keyed by k.
  function automatic logic [BW-1:0] pat(input logic [7:0] k, input logic v);
    logic [W-1:0] pc;
    pc = 32'h0000_1000 + {22'd0, k, 2'b00};
    return {v, k[0], k[1], k[2], k[3], k[4], k[5], k[6], k[1:0], k[3:0], k[2:0], k[5:3],
            k[4:0], 5'(k + 8'd1), 5'(k + 8'd2),
            32'hA000_0000 | {24'd0, k}, 32'hB000_0000 | {24'd0, k},
            32'hC000_0000 | {24'd0, k}, pc, pc + 32'd4};
  endfunction

  task automatic put(input logic [BW-1:0] b);
    {valid_D, regWrite_D, jump_D, branch_D, ALUsrc_D, jalr_D, lui_D,
     load_extend_s_D, resultSrc_D, ALUctrl_D, R_size_D, DMem_size_D,
     Rd_D, Rs1_D, Rs2_D, RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D} = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; stall_E = 1'b0; flush_E = 1'b0;
    put('1);
    step();
    // Asynchronous reset mid-cycle: outputs clear before any edge.
    rst = 1'b1;
    #1;
    chk("reset_bus", 256'(e_bus), 256'(0));
    chk("reset_cnt", 256'(bubble_cnt), 256'(0));
    rst = 1'b0;

    // Pass-through of a sparse instruction.
    put('0);
    valid_D = 1'b1; regWrite_D = 1'b1; Rd_D = 5'd5; RD1_D = 32'h1234; PC_D = 32'h100;
    step();
    chk("pt_valid", 256'(valid_E), 256'(1));
    chk("pt_regwrite", 256'(regWrite_E), 256'(1));
    chk("pt_rd", 256'(Rd_E), 256'(5));
    chk("pt_rd1", 256'(RD1_E), 256'(32'h1234));
    chk("pt_pc", 256'(PC_E), 256'(32'h100));
    Rd_D = 5'd9; RD1_D = 32'hFFFF; PC_D = 32'h200;
    #2;
    chk("pt_hold_rd", 256'(Rd_E), 256'(5));
    chk("pt_hold_rd1", 256'(RD1_E), 256'(32'h1234));

    // Every field with two complementary patterns.
    put(pat(8'h5A, 1'b1));
    step();
    chk("full_5a", 256'(e_bus), 256'(pat(8'h5A, 1'b1)));
    put(pat(8'hA5, 1'b1));
    step();
    chk("full_a5", 256'(e_bus), 256'(pat(8'hA5, 1'b1)));

    // Stall holds A (Rd=3) while B (Rd=7) waits.
    put(pat(8'h03, 1'b1));
    step();
    stall_E = 1'b1;
    put(pat(8'h07, 1'b1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rd", 256'(Rd_E), 256'(3));
    end
    chk("stall_bus", 256'(e_bus), 256'(pat(8'h03, 1'b1)));
    chk("stall_cnt", 256'(bubble_cnt), 256'(0));
    stall_E = 1'b0;
    step();
    chk("unstall_rd", 256'(Rd_E), 256'(7));
    chk("unstall_bus", 256'(e_bus), 256'(pat(8'h07, 1'b1)));

    // Flush inserts an all-zero bubble.
    put(pat(8'h21, 1'b1));
    step();
    flush_E = 1'b1;
    step();
    chk("flush_bus", 256'(e_bus), 256'(0));
    chk("flush_rd", 256'(Rd_E), 256'(0));
    chk("flush_cnt", 256'(bubble_cnt), 256'(1));
    flush_E = 1'b0;
    put(pat(8'h44, 1'b1));
    step();
    chk("postflush_bus", 256'(e_bus), 256'(pat(8'h44, 1'b1)));
    chk("postflush_cnt", 256'(bubble_cnt), 256'(1));

    // Flush wins over stall; the held instruction is discarded.
    put(pat(8'h12, 1'b1));
    step();
    stall_E = 1'b1; flush_E = 1'b1;
    put(pat(8'h13, 1'b1));
    step();
    chk("fs_bus", 256'(e_bus), 256'(0));
    chk("fs_cnt", 256'(bubble_cnt), 256'(2));
    flush_E = 1'b0;
    step();
    chk("fs_hold_bus", 256'(e_bus), 256'(0));
    chk("fs_hold_cnt", 256'(bubble_cnt), 256'(2));
    stall_E = 1'b0;
    step();
    chk("fs_release", 256'(e_bus), 256'(pat(8'h13, 1'b1)));

    // valid_D = 0 passes fields through untouched.
    put(pat(8'h6C, 1'b0));
    step();
    chk("invalid_pass", 256'(e_bus), 256'(pat(8'h6C, 1'b0)));

    // Reset during a stall clears everything at once.
    stall_E = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_stall_bus", 256'(e_bus), 256'(0));
    chk("rst_stall_cnt", 256'(bubble_cnt), 256'(0));
    rst = 1'b0;
    stall_E = 1'b0;

    // Counter wrap after 65536 flushes.
    flush_E = 1'b1;
    for (int i = 0; i < 65536; i++) step();
    chk("wrap_cnt", 256'(bubble_cnt), 256'(0));
    chk("wrap_bus", 256'(e_bus), 256'(0));
    step();
    chk("wrap_plus1", 256'(bubble_cnt), 256'(1));
    flush_E = 1'b0;
    step();
    chk("wrap_capture", 256'(e_bus), 256'(pat(8'h6C, 1'b0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_reg_de.md
# pipe_reg_de

Decode-to-execute pipeline register for the five-stage RV32I core. Captures every control and data field produced by the decode stage, plus the source-register addresses and PC values, and presents them to the execute stage one cycle later. Supports hazard-unit stall (hold) and flush (bubble insertion). Keeps a free-running count of inserted bubbles for performance debug.

## Interface
Parameters:
- WIDTH, 32, datapath width for register data, immediate and PC fields.

Ports:
- clk, input, 1, core clock; all state updates on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- stall_E, input, 1, hold current contents (from hazard unit).
- flush_E, input, 1, load a bubble on the next edge (from hazard unit).
- valid_D, input, 1, decode slot holds a real instruction.
- regWrite_D, jump_D, branch_D, ALUsrc_D, jalr_D, lui_D, load_extend_s_D, input, 1 each, decode control bits.
- resultSrc_D, input, 2, result mux select.
- ALUctrl_D, input, 4, ALU operation.
- R_size_D, DMem_size_D, input, 3 each, access-size codes.
- Rd_D, Rs1_D, Rs2_D, input, 5 each, register addresses.
- RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D, input, WIDTH each, operand, immediate and PC values.
- Every *_D input above has a matching *_E output of identical width (valid_E, regWrite_E, …, PCPlus4_E).
- bubble_cnt, output, 16, number of bubbles inserted since reset.

## Operation
- Register update on each rising clk edge, priority order:
  1. rst high: all *_E outputs 0, bubble_cnt 0. Asynchronous: takes effect immediately, independent of clk.
  2. flush_E high: load a bubble; bubble_cnt increments by 1.
  3. stall_E high (flush_E low): every *_E output holds its value; bubble_cnt holds.
  4. Otherwise: every *_E output takes its *_D input.
- Bubble contents:
  - All *_E outputs, control and data, are 0, including valid_E, regWrite_E, branch_E, jump_E, jalr_E and Rd_E.
  - Zeroed data keeps traces deterministic.
  - Rd_E = 0 guarantees the bubble cannot match a forwarding compare.
- flush_E together with stall_E: flush wins. A bubble is loaded and the stalled instruction is discarded; the hazard unit relies on this when resolving a taken branch during a load-use stall.
- A normal load with valid_D = 0 passes the fields through unchanged. Only flush forces the bubble pattern.
- bubble_cnt wraps from 0xFFFF to 0x0000 with no flag.
- No combinational path from any input to any output; all outputs come directly from flops.

## Timing
- Latency: 1 cycle; *_D values present before edge n appear on *_E after edge n.
- stall_E and flush_E are sampled on the same edge as the data. A stall asserted in cycle n keeps the edge-n contents visible through cycle n+1.
- Reset deassertion: the first capture happens on the first rising edge with rst low.
- Reset asserted mid-stall or mid-flush clears everything immediately; no pending operation survives.
- Throughput: one instruction per cycle when neither stall_E nor flush_E is asserted.

## Test plan
- Reset: drive all *_D = 1s, pulse rst between edges -> all *_E = 0 and bubble_cnt = 0 immediately, before any clk edge.
- Pass-through: valid_D=1, regWrite_D=1, Rd_D=5, RD1_D=0x1234, PC_D=0x100, one edge -> *_E match (Rd_E=5, RD1_E=0x1234, PC_E=0x100, valid_E=1); change inputs with no edge -> outputs unchanged.
- Stall: load instr A (Rd_D=3), then stall_E=1 for 3 edges while *_D = instr B (Rd_D=7) -> Rd_E stays 3; deassert stall_E -> Rd_E=7 after next edge.
- Flush: load A, assert flush_E for one edge -> valid_E=0, regWrite_E=0, Rd_E=0, RD1_E=0, bubble_cnt=1; next edge with flush low -> current *_D captured.
- Flush+stall: stall_E=1 and flush_E=1 on same edge -> bubble loaded and bubble_cnt incremented; the held instruction is gone.
- Counter wrap: 65536 consecutive flush edges -> bubble_cnt returns to 0x0000; one more flush -> 0x0001.
